// File: rtl/basic_div_pkg.sv
// Shared types and default widths for the basic_div restoring divider.
package basic_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    localparam int unsigned DIVIDEND_W_DEF = 18;
    localparam int unsigned DIVISOR_W_DEF  = 8;

    // Counter must hold the value DIVIDEND_W itself, hence the +1.
    function automatic int unsigned cnt_w(input int unsigned dividend_w);
        return $clog2(dividend_w + 1);
    endfunction

    localparam int unsigned CNT_W_DEF = cnt_w(DIVIDEND_W_DEF);

endpackage

// File: rtl/BUFG.sv
// Behavioural stand-in for the vendor global clock buffer.
module BUFG (
    output logic O,
    input  logic I
);
    assign O = I;
endmodule

// File: rtl/IBUFDS.sv
// Behavioural stand-in for the vendor differential input buffer.
module IBUFDS (
    output logic O,
    input  logic I,
    input  logic IB
);
    assign O = I & ~IB;
endmodule

// File: rtl/basic_div_core.sv
// Unsigned restoring divider: FSM plus one-quotient-bit-per-clock datapath.
module basic_div_core
    import basic_div_pkg::*;
#(
    parameter int unsigned DIVIDEND_W = DIVIDEND_W_DEF,
    parameter int unsigned DIVISOR_W  = DIVISOR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int unsigned CNT_W = cnt_w(DIVIDEND_W);

    state_e                state_q, state_d;
    logic                  in_ready_q, in_ready_d;
    logic [DIVISOR_W:0]    rem_q, rem_d;
    logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
    logic [DIVISOR_W-1:0]  dvd_lo_q, dvd_lo_d;
    logic [DIVISOR_W-1:0]  divisor_q, divisor_d;
    logic                  zero_q, zero_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
    logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
    logic                  dbz_q, dbz_d;

    // One extra bit above the partial remainder makes the subtraction exact.
    logic [DIVISOR_W+1:0]  shifted;
    logic [DIVISOR_W+1:0]  trial;
    logic                  negative;

    always_comb begin
        shifted  = {rem_q, dvd_q[DIVIDEND_W-1]};
        trial    = shifted - {2'b00, divisor_q};
        negative = trial[DIVISOR_W+1];
    end

    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        dvd_d       = dvd_q;
        dvd_lo_d    = dvd_lo_q;
        divisor_d   = divisor_q;
        zero_d      = zero_q;
        count_d     = count_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    dvd_d     = dividend;
                    dvd_lo_d  = dividend[DIVISOR_W-1:0];
                    divisor_d = divisor;
                    zero_d    = (divisor == '0);
                    rem_d     = '0;
                    count_d   = CNT_W'(DIVIDEND_W);
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (count_q != '0) begin
                    rem_d   = negative ? shifted[DIVISOR_W:0] : trial[DIVISOR_W:0];
                    dvd_d   = {dvd_q[DIVIDEND_W-2:0], ~negative};
                    count_d = count_q - 1'b1;
                end else begin
                    quotient_d  = zero_q ? '1 : dvd_q;
                    remainder_d = zero_q ? dvd_lo_q : rem_q[DIVISOR_W-1:0];
                    dbz_d       = zero_q;
                    state_d     = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dvd_lo_q    <= '0;
            divisor_q   <= '0;
            zero_q      <= 1'b0;
            count_q     <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            rem_q       <= rem_d;
            dvd_q       <= dvd_d;
            dvd_lo_q    <= dvd_lo_d;
            divisor_q   <= divisor_d;
            zero_q      <= zero_d;
            count_q     <= count_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = (state_q == DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: rtl/basic_div.sv
// Board-level wrapper: differential clock buffered onto a global net, then the divider core.
module basic_div
    import basic_div_pkg::*;
#(
    parameter int unsigned DIVIDEND_W = DIVIDEND_W_DEF,
    parameter int unsigned DIVISOR_W  = DIVISOR_W_DEF
) (
    input  logic                  clk_p,
    input  logic                  clk_n,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    logic clk_ibuf;
    logic clk;

    IBUFDS u_ibufds (
        .O  (clk_ibuf),
        .I  (clk_p),
        .IB (clk_n)
    );

    BUFG u_bufg (
        .O (clk),
        .I (clk_ibuf)
    );

    basic_div_core #(
        .DIVIDEND_W (DIVIDEND_W),
        .DIVISOR_W  (DIVISOR_W)
    ) u_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

endmodule
